// File: rtl/cam_match_array.sv
// Search side of the CAM: one-hot presence array fed by the write/erase stream,
// answering key searches with the lowest matching address. Optional CAM_MULTI_MATCH_EN adds match_count/multi_hit.
module cam_match_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write,
  input  logic [ADDR_WIDTH-1:0]    write_addr,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     erase,
  input  logic [ADDR_WIDTH-1:0]    erase_addr,
  input  logic [DATA_WIDTH-1:0]    erase_data,
  input  logic                     search_valid,
  output logic                     search_ready,
  input  logic [DATA_WIDTH-1:0]    search_key,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     match,
  output logic [ADDR_WIDTH-1:0]    match_addr,
  output logic [2**ADDR_WIDTH-1:0] match_vector
`ifdef CAM_MULTI_MATCH_EN
  ,
  output logic [ADDR_WIDTH:0]      match_count,
  output logic                     multi_hit
`endif
);

  localparam int ROWS = 2**DATA_WIDTH;
  localparam int COLS = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, LOOKUP, ENCODE, RESP} state_t;

  state_t                state;
  logic [COLS-1:0]       presence [ROWS];
  logic [DATA_WIDTH-1:0] last_wdata [COLS];
  logic [DATA_WIDTH-1:0] key;
  logic                  erase_en;

  function automatic logic [ADDR_WIDTH-1:0] lowest_index(input logic [COLS-1:0] v);
    logic [ADDR_WIDTH-1:0] idx;
    idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (v[i]) idx = ADDR_WIDTH'(i);
    end
    return idx;
  endfunction

`ifdef CAM_MULTI_MATCH_EN
  function automatic logic [ADDR_WIDTH:0] pop_count(input logic [COLS-1:0] v);
    logic [ADDR_WIDTH:0] cnt;
    cnt = '0;
    for (int i = 0; i < COLS; i++) begin
      if (v[i]) cnt = cnt + (ADDR_WIDTH+1)'(1);
    end
    return cnt;
  endfunction
`endif

  // A lagging erase that carries the data just written to that address is a rewrite of identical data.
  assign erase_en = erase && (erase_data != last_wdata[erase_addr]);

  // The write is scheduled after the erase so the set wins when both hit the same bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) presence[r] <= '0;
      for (int c = 0; c < COLS; c++) last_wdata[c] <= '0;
    end else begin
      if (erase_en) presence[erase_data][erase_addr] <= 1'b0;
      if (write) begin
        presence[write_data][write_addr] <= 1'b1;
        last_wdata[write_addr]           <= write_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      search_ready <= 1'b1;
      result_valid <= 1'b0;
      match        <= 1'b0;
      match_addr   <= '0;
      match_vector <= '0;
      key          <= '0;
`ifdef CAM_MULTI_MATCH_EN
      match_count  <= '0;
      multi_hit    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (search_valid) begin
            key          <= search_key;
            search_ready <= 1'b0;
            state        <= LOOKUP;
          end
        end
        LOOKUP: begin
          match_vector <= presence[key];
          state        <= ENCODE;
        end
        ENCODE: begin
          match        <= |match_vector;
          match_addr   <= lowest_index(match_vector);
          result_valid <= 1'b1;
`ifdef CAM_MULTI_MATCH_EN
          match_count  <= pop_count(match_vector);
          multi_hit    <= (pop_count(match_vector) > (ADDR_WIDTH+1)'(1));
`endif
          state        <= RESP;
        end
        RESP: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            search_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_match_array.sv
// Bench for cam_match_array: set-based reference model compared every cycle,
// plus directed searches with hand-computed results.
module tb_cam_match_array;

  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int COLS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          write;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          erase;
  logic [AW-1:0] erase_addr;
  logic [DW-1:0] erase_data;
  logic          search_valid;
  logic          search_ready;
  logic [DW-1:0] search_key;
  logic          result_valid;
  logic          result_ready;
  logic          match;
  logic [AW-1:0] match_addr;
  logic [COLS-1:0] match_vector;
`ifdef CAM_MULTI_MATCH_EN
  logic [AW:0]   match_count;
  logic          multi_hit;
`endif

  always #5 clk = ~clk;

  cam_match_array #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .write        (write),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .erase        (erase),
    .erase_addr   (erase_addr),
    .erase_data   (erase_data),
    .search_valid (search_valid),
    .search_ready (search_ready),
    .search_key   (search_key),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .match        (match),
    .match_addr   (match_addr),
    .match_vector (match_vector)
`ifdef CAM_MULTI_MATCH_EN
    ,
    .match_count  (match_count),
    .multi_hit    (multi_hit)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, required, $time);
    end
  endtask

  // Reference model: the set of (data, address) pairs present, plus the search transaction in flight.
  bit            m_pres [256][COLS];
  logic [DW-1:0] m_last [COLS];
  int            m_phase;
  logic [COLS-1:0] m_snap;
  logic          m_ready, m_valid, m_match;
  logic [AW-1:0] m_addr;
  logic [COLS-1:0] m_vector;
  int            m_count;

  function automatic logic [AW-1:0] lowest_of(input logic [COLS-1:0] v);
    for (int i = 0; i < COLS; i++) if (v[i]) return AW'(i);
    return '0;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 256; d++) for (int a = 0; a < COLS; a++) m_pres[d][a] = 1'b0;
      for (int a = 0; a < COLS; a++) m_last[a] = '0;
      m_phase = 0; m_snap = '0; m_ready = 1'b1; m_valid = 1'b0;
      m_match = 1'b0; m_addr = '0; m_vector = '0; m_count = 0;
    end else begin
      int old_phase;
      bit erase_ok;
      old_phase = m_phase;
      case (old_phase)
        1: begin m_vector = m_snap; m_phase = 2; end
        2: begin
          m_match = (m_snap != '0);
          m_addr  = lowest_of(m_snap);
          m_count = $countones(m_snap);
          m_valid = 1'b1;
          m_phase = 3;
        end
        3: if (result_ready) begin m_valid = 1'b0; m_ready = 1'b1; m_phase = 0; end
        default: ;
      endcase
      erase_ok = erase && (erase_data != m_last[erase_addr]);
      if (erase_ok) m_pres[erase_data][erase_addr] = 1'b0;
      if (write) begin
        m_pres[write_data][write_addr] = 1'b1;
        m_last[write_addr] = write_data;
      end
      if (old_phase == 0 && search_valid) begin
        for (int a = 0; a < COLS; a++) m_snap[a] = m_pres[search_key][a];
        m_ready = 1'b0;
        m_phase = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check_output("search_ready", 32'(search_ready), 32'(m_ready));
      check_output("result_valid", 32'(result_valid), 32'(m_valid));
      check_output("match_vector", 32'(match_vector), 32'(m_vector));
      check_output("match",        32'(match),        32'(m_match));
      check_output("match_addr",   32'(match_addr),   32'(m_addr));
`ifdef CAM_MULTI_MATCH_EN
      check_output("match_count",  32'(match_count),  32'(m_count));
      check_output("multi_hit",    32'(multi_hit),    32'(m_count > 1));
`endif
    end
  end

  task automatic apply_stimulus(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input bit e, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    write = w; write_addr = wa; write_data = wd;
    erase = e; erase_addr = ea; erase_data = ed;
    @(negedge clk);
    write = 1'b0; erase = 1'b0;
  endtask

  task automatic run_search(input logic [DW-1:0] key, input bit rr, output int lat);
    search_key = key; search_valid = 1'b1; result_ready = rr;
    @(negedge clk);
    search_valid = 1'b0;
    lat = 0;
    while (result_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 10) begin
      vectors++; miscompares++;
      $display("[TB] FAIL search_timeout: key 0x%0h, result_valid never rose", key);
    end
  endtask

  task automatic finish_search();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input bit em, input logic [AW-1:0] ea, input logic [COLS-1:0] ev);
    check_output({name, ".match"},        32'(match),        32'(em));
    check_output({name, ".match_addr"},   32'(match_addr),   32'(ea));
    check_output({name, ".match_vector"}, 32'(match_vector), 32'(ev));
  endtask

  initial begin
    int lat;
    rst = 1'b0; write = 1'b0; write_addr = '0; write_data = '0;
    erase = 1'b0; erase_addr = '0; erase_data = '0;
    search_valid = 1'b0; search_key = '0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    check_output("reset.search_ready", 32'(search_ready), 32'd1);
    check_output("reset.result_valid", 32'(result_valid), 32'd0);
    check_result("reset", 1'b0, 2'd0, 4'b0000);
    rst = 1'b1;
    @(negedge clk);

    // Empty array: no match reports address 0
    run_search(8'h00, 1'b0, lat);
    check_result("empty", 1'b0, 2'd0, 4'b0000);
    finish_search();

    // Single entry, latency of two edges after acceptance
    apply_stimulus(1, 2'd2, 8'h5A, 0, 2'd0, 8'h00);
    run_search(8'h5A, 1'b0, lat);
    check_output("t1.latency", 32'(lat), 32'd2);
    check_result("t1", 1'b1, 2'd2, 4'b0100);
    finish_search();
    check_output("t1.ready_after", 32'(search_ready), 32'd1);

    // Overwrite with lagging erase of the old data
    apply_stimulus(1, 2'd1, 8'h11, 0, 2'd0, 8'h00);
    apply_stimulus(1, 2'd1, 8'h22, 0, 2'd0, 8'h00);
    apply_stimulus(0, 2'd0, 8'h00, 1, 2'd1, 8'h11);
    run_search(8'h11, 1'b0, lat);
    check_result("t2a", 1'b0, 2'd0, 4'b0000);
    finish_search();
    run_search(8'h22, 1'b1, lat);
    check_result("t2b", 1'b1, 2'd1, 4'b0010);
    finish_search();
    check_output("t2b.fast_ready", 32'(search_ready), 32'd1);

    // Identical rewrite: erase suppressed
    apply_stimulus(1, 2'd0, 8'h33, 0, 2'd0, 8'h00);
    apply_stimulus(1, 2'd0, 8'h33, 0, 2'd0, 8'h00);
    apply_stimulus(0, 2'd0, 8'h00, 1, 2'd0, 8'h33);
    run_search(8'h33, 1'b0, lat);
    check_result("t3", 1'b1, 2'd0, 4'b0001);
    finish_search();

    // Write and unsuppressed erase on the same bit in one edge: set wins
    apply_stimulus(1, 2'd2, 8'h66, 0, 2'd0, 8'h00);
    apply_stimulus(1, 2'd2, 8'h44, 1, 2'd2, 8'h44);
    run_search(8'h44, 1'b0, lat);
    check_result("setwins", 1'b1, 2'd2, 4'b0100);
    finish_search();

    // Multiple hits
    apply_stimulus(1, 2'd3, 8'h7E, 0, 2'd0, 8'h00);
    apply_stimulus(1, 2'd1, 8'h7E, 0, 2'd0, 8'h00);
    run_search(8'h7E, 1'b0, lat);
    check_result("t4", 1'b1, 2'd1, 4'b1010);
`ifdef CAM_MULTI_MATCH_EN
    check_output("t4.match_count", 32'(match_count), 32'd2);
    check_output("t4.multi_hit",   32'(multi_hit),   32'd1);
`endif
    finish_search();

    // Stalled result stays stable while the array changes underneath
    run_search(8'h7E, 1'b0, lat);
    apply_stimulus(1, 2'd0, 8'h7E, 0, 2'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check_output("t5.hold_valid", 32'(result_valid), 32'd1);
      check_output("t5.hold_ready", 32'(search_ready), 32'd0);
      check_result("t5.hold", 1'b1, 2'd1, 4'b1010);
      @(negedge clk);
    end
    finish_search();
    run_search(8'h7E, 1'b0, lat);
    check_result("t5.after", 1'b1, 2'd0, 4'b1011);
    finish_search();

    // Reset while in LOOKUP aborts the search
    search_key = 8'h33; search_valid = 1'b1;
    @(negedge clk);
    search_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_output("t6.no_result", 32'(result_valid), 32'd0);
      @(negedge clk);
    end
    run_search(8'h33, 1'b0, lat);
    check_result("t6.cleared", 1'b0, 2'd0, 4'b0000);
    finish_search();

    repeat (2) @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cam_match_array.md
Name: cam_match_array

Overview:
- Search side of the CAM; consumes the write/erase stream from the CAM's erase RAM.
- Keeps a one-hot presence array indexed by data value, with one column per RAM address.
- Answers key searches with the lowest matching address through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, key/data width; the array has 2**DATA_WIDTH rows.
- ADDR_WIDTH, 2, address width; each row has 2**ADDR_WIDTH columns.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-low reset
- write  in  1  set presence bit [write_data][write_addr]
- write_addr  in  ADDR_WIDTH  address being written
- write_data  in  DATA_WIDTH  new data at write_addr
- erase  in  1  clear presence bit [erase_data][erase_addr]; arrives one cycle after its write
- erase_addr  in  ADDR_WIDTH  address whose previous contents are erased
- erase_data  in  DATA_WIDTH  previous data at erase_addr
- search_valid  in  1  search request
- search_ready  out  1  high only in IDLE
- search_key  in  DATA_WIDTH  key to look up
- result_valid  out  1  result held until accepted
- result_ready  in  1  result consumer ready
- match  out  1  at least one address holds the key
- match_addr  out  ADDR_WIDTH  lowest matching address; 0 when no match
- match_vector  out  2**ADDR_WIDTH  raw row for the key

Behaviour:
Reset:
- rst==0 at a clk edge clears every presence bit and every last_wdata entry.
- FSM goes to IDLE.
- result_valid, match, match_addr and match_vector all become 0.
- search_ready is 1 in the first cycle after reset.
- Reset mid-search aborts the search; no result is produced.

Update path (independent of the FSM, applied every cycle):
- Write: on an edge with write==1, bit [write_data][write_addr] is set and last_wdata[write_addr] <= write_data.
- Erase: on an edge with erase==1, bit [erase_data][erase_addr] is cleared, except when suppressed.
- Erase suppression: the erase is ignored when erase_data == last_wdata[erase_addr]. This protects a rewrite of identical data.
- Same edge, same bit: when write and erase hit the same bit, the set wins.
- Suppression compares against last_wdata before that edge's write updates it.

Search FSM:
- IDLE:
  - search_ready=1.
  - search_valid at edge T captures search_key -> LOOKUP.
- LOOKUP:
  - At edge T+1, row[key] is registered into match_vector -> ENCODE.
  - The registered row reflects all updates at edges <= T.
  - Updates at edge T+1 or later are not reflected.
- ENCODE:
  - At edge T+2, match = |match_vector.
  - match_addr = lowest set index, or 0 when no bit is set.
  - result_valid=1 -> RESP.
- RESP:
  - Outputs are held stable.
  - result_ready==1 at an edge -> IDLE and result_valid=0.
  - result_ready may already be high when result_valid rises. The result then completes in one cycle, giving a minimum 4-cycle search period.
- Searches are never dropped. search_valid outside IDLE is simply not accepted.

Optional Feature:
- Macro: CAM_MULTI_MATCH_EN.
- Defined:
  - Adds output match_count (ADDR_WIDTH+1 bits, popcount of match_vector).
  - Adds output multi_hit (match_count>1).
  - Both are registered in ENCODE and reset to 0.
- Undefined:
  - Neither port exists.
  - All other behaviour is identical.

Test Plan:
- Reset, then write 0x5A to addr 2, then search 0x5A -> result_valid 2 edges after acceptance; match=1, match_addr=2, match_vector=4'b0100.
- Write 0x11 to addr 1, then write 0x22 to addr 1 with erase_data=0x11 on the next cycle -> search 0x11 gives match=0, match_addr=0; search 0x22 gives match=1, match_addr=1.
- Write 0x33 to addr 0 twice, with the lagging erase carrying erase_data=0x33 -> erase suppressed; search 0x33 gives match=1, match_addr=0.
- Write 0x7E to addrs 3 and 1 -> search 0x7E gives match_vector=4'b1010, match_addr=1; with CAM_MULTI_MATCH_EN, match_count=2 and multi_hit=1.
- Hold result_ready=0 for 5 cycles in RESP while writing 0x7E to addr 0 -> outputs stay stable and search_ready=0; after result_ready, a new search sees addr 0.
- Assert rst=0 during LOOKUP -> result_valid never rises; a search for a previously written key then gives match=0.
